// File: rtl/fuzzy_defuzz_pkg.sv
// Shared definitions for the type-2 fuzzy defuzzification back end:
// default sizes, derived accumulator widths, FSM state encoding and the
// universe midpoint used as the fallback output for an empty rule base.
package fuzzy_defuzz_pkg;

    localparam int W_DEF        = 8;
    localparam int N_REGRAS_DEF = 9;
    localparam int NUM_W_DEF    = 2 * W_DEF + 5;
    localparam int DEN_W_DEF    = W_DEF + 5;

    localparam logic [W_DEF-1:0] MEIO_DEF = 8'd128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACUM = 2'd1,
        DIV  = 2'd2,
        FIM  = 2'd3
    } estado_t;

endpackage

// File: rtl/bloco_defuzzificador_divisor_serial.sv
// Serial restoring divider: one quotient bit per step, MSB first, with
// round-half-up applied combinationally on the final remainder.
// load captures dividend/divisor; step performs one trial subtraction;
// done marks the step that produces the last quotient bit.
module divisor_serial
    import fuzzy_defuzz_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int NUM_W = NUM_W_DEF,
    parameter int DEN_W = DEN_W_DEF
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             load,
    input  logic             step,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [W-1:0]     quoc,
    output logic             den_zero
);

    localparam int KW = $clog2(W);

    logic [NUM_W-1:0] resto_r;
    logic [DEN_W-1:0] div_r;
    logic [W-1:0]     q_r;
    logic [KW-1:0]    k_r;

    logic [NUM_W-1:0] trial_s;
    logic [NUM_W:0]   dobro_s;
    logic             arred_s;

    // Trial subtrahend, completion flag and rounded quotient.
    always_comb begin
        trial_s  = {{(NUM_W-DEN_W){1'b0}}, div_r} << k_r;
        dobro_s  = {resto_r, 1'b0};
        arred_s  = (dobro_s >= {{(NUM_W+1-DEN_W){1'b0}}, div_r});
        quoc     = q_r + {{(W-1){1'b0}}, arred_s};
        den_zero = (div_r == {DEN_W{1'b0}});
        if (step && (k_r == {KW{1'b0}})) begin
            done = 1'b1;
        end else begin
            done = 1'b0;
        end
    end

    // Remainder/quotient registers: load a new problem or resolve one bit per step.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            resto_r <= {NUM_W{1'b0}};
            div_r   <= {DEN_W{1'b0}};
            q_r     <= {W{1'b0}};
            k_r     <= {KW{1'b0}};
        end else if (load) begin
            resto_r <= num;
            div_r   <= den;
            q_r     <= {W{1'b0}};
            k_r     <= KW'(W - 1);
        end else if (step) begin
            if (resto_r >= trial_s) begin
                resto_r  <= resto_r - trial_s;
                q_r[k_r] <= 1'b1;
            end
            k_r <= k_r - {{(KW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/bloco_defuzzificador.sv
// Nie-Tan type reduction and defuzzification for the interval type-2 fuzzy
// controller: y = sum(c_i*(up_i+low_i)) / sum(up_i+low_i), one rule per
// enabled cycle followed by a serial divide and a rounding/commit cycle.
// Optional build macro DEFUZ_ZERO_FLAG_EN: adds erro_zero and keeps the
// previous output when every rule weight is zero; otherwise the output
// falls back to the universe midpoint in that case.
module bloco_defuzzificador
    import fuzzy_defuzz_pkg::*;
#(
    parameter int N_REGRAS = N_REGRAS_DEF,
    parameter int W        = W_DEF
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  EN_SCLK,
    input  logic                  start,
    input  logic [N_REGRAS*W-1:0] regra_UP,
    input  logic [N_REGRAS*W-1:0] regra_LOW,
    input  logic [N_REGRAS*W-1:0] centroide,
    input  logic [N_REGRAS-1:0]   regra_ativa,
    output logic                  busy,
    output logic                  done,
`ifdef DEFUZ_ZERO_FLAG_EN
    output logic                  erro_zero,
`endif
    output logic [W-1:0]          saida_crisp
);

    localparam int NUM_W = 2 * W + 5;
    localparam int DEN_W = W + 5;
    localparam int IDX_W = $clog2(N_REGRAS);
    localparam logic [W-1:0] MEIO = {1'b1, {(W-1){1'b0}}};

    estado_t               estado_r;
    logic [N_REGRAS*W-1:0] up_r;
    logic [N_REGRAS*W-1:0] low_r;
    logic [N_REGRAS*W-1:0] cent_r;
    logic [N_REGRAS-1:0]   ativa_r;
    logic [IDX_W-1:0]      idx_r;
    logic [NUM_W-1:0]      num_r;
    logic [DEN_W-1:0]      den_r;
    logic                  busy_r;
    logic                  done_r;
    logic [W-1:0]          saida_r;
`ifdef DEFUZ_ZERO_FLAG_EN
    logic                  erro_r;
`endif

    logic [W-1:0]     up_s;
    logic [W-1:0]     low_s;
    logic [W-1:0]     c_s;
    logic [W:0]       s_s;
    logic [2*W:0]     prod_s;
    logic [NUM_W-1:0] num_next_s;
    logic [DEN_W-1:0] den_next_s;
    logic             ultima_s;
    logic             load_s;
    logic             step_s;
    logic             div_done_s;
    logic [W-1:0]     div_quoc_s;
    logic             div_den_zero_s;

    // Current rule weight, weighted contribution and next accumulator values.
    always_comb begin
        up_s  = up_r[idx_r*W +: W];
        low_s = low_r[idx_r*W +: W];
        c_s   = cent_r[idx_r*W +: W];
        if (ativa_r[idx_r]) begin
            s_s = {1'b0, up_s} + {1'b0, low_s};
        end else begin
            s_s = {(W+1){1'b0}};
        end
        prod_s     = {{(W+1){1'b0}}, c_s} * {{W{1'b0}}, s_s};
        num_next_s = num_r + {{(NUM_W-2*W-1){1'b0}}, prod_s};
        den_next_s = den_r + {{(DEN_W-W-1){1'b0}}, s_s};
        ultima_s   = (idx_r == IDX_W'(N_REGRAS - 1));
    end

    // Divider control: load the final sums straight off the last MAC step.
    always_comb begin
        if (EN_SCLK && (estado_r == ACUM) && ultima_s) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        if (EN_SCLK && (estado_r == DIV)) begin
            step_s = 1'b1;
        end else begin
            step_s = 1'b0;
        end
    end

    divisor_serial #(
        .W     (W),
        .NUM_W (NUM_W),
        .DEN_W (DEN_W)
    ) u_divisor (
        .clk      (clk),
        .RESET    (RESET),
        .load     (load_s),
        .step     (step_s),
        .num      (num_next_s),
        .den      (den_next_s),
        .done     (div_done_s),
        .quoc     (div_quoc_s),
        .den_zero (div_den_zero_s)
    );

    // Control FSM, input capture, MAC accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            estado_r <= IDLE;
            up_r     <= {(N_REGRAS*W){1'b0}};
            low_r    <= {(N_REGRAS*W){1'b0}};
            cent_r   <= {(N_REGRAS*W){1'b0}};
            ativa_r  <= {N_REGRAS{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            num_r    <= {NUM_W{1'b0}};
            den_r    <= {DEN_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            saida_r  <= {W{1'b0}};
`ifdef DEFUZ_ZERO_FLAG_EN
            erro_r   <= 1'b0;
`endif
        end else if (EN_SCLK) begin
            case (estado_r)
                IDLE: begin
                    // busy_r still high here means done is showing: ignore start.
                    if (start && !busy_r) begin
                        up_r     <= regra_UP;
                        low_r    <= regra_LOW;
                        cent_r   <= centroide;
                        ativa_r  <= regra_ativa;
                        idx_r    <= {IDX_W{1'b0}};
                        num_r    <= {NUM_W{1'b0}};
                        den_r    <= {DEN_W{1'b0}};
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                        estado_r <= ACUM;
                    end else begin
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                end
                ACUM: begin
                    num_r <= num_next_s;
                    den_r <= den_next_s;
                    if (ultima_s) begin
                        estado_r <= DIV;
                    end else begin
                        idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                DIV: begin
                    if (div_done_s) begin
                        estado_r <= FIM;
                    end
                end
                FIM: begin
                    done_r   <= 1'b1;
                    estado_r <= IDLE;
                    if (div_den_zero_s) begin
`ifdef DEFUZ_ZERO_FLAG_EN
                        erro_r  <= 1'b1;
`else
                        saida_r <= MEIO;
`endif
                    end else begin
                        saida_r <= div_quoc_s;
`ifdef DEFUZ_ZERO_FLAG_EN
                        erro_r  <= 1'b0;
`endif
                    end
                end
                default: begin
                    estado_r <= IDLE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign saida_crisp = saida_r;
`ifdef DEFUZ_ZERO_FLAG_EN
    assign erro_zero   = erro_r;
`endif

endmodule

// File: tb/tb_bloco_defuzzificador.sv
// Directed self-checking bench for bloco_defuzzificador (default sizes).
// Honors DEFUZ_ZERO_FLAG_EN so the same bench covers both builds.
module tb_bloco_defuzzificador;

    localparam int N = 9;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           RESET;
    logic           EN_SCLK;
    logic           start;
    logic [N*W-1:0] regra_UP;
    logic [N*W-1:0] regra_LOW;
    logic [N*W-1:0] centroide;
    logic [N-1:0]   regra_ativa;
    logic           busy;
    logic           done;
    logic [W-1:0]   saida_crisp;
`ifdef DEFUZ_ZERO_FLAG_EN
    logic           erro_zero;
`endif

    int errors = 0;
    int checks = 0;

    int   en_cyc;
    int   clk_cyc;
    logic saw_done;

    bloco_defuzzificador dut (
        .clk         (clk),
        .RESET       (RESET),
        .EN_SCLK     (EN_SCLK),
        .start       (start),
        .regra_UP    (regra_UP),
        .regra_LOW   (regra_LOW),
        .centroide   (centroide),
        .regra_ativa (regra_ativa),
        .busy        (busy),
        .done        (done),
`ifdef DEFUZ_ZERO_FLAG_EN
        .erro_zero   (erro_zero),
`endif
        .saida_crisp (saida_crisp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rules();
        regra_UP    = '0;
        regra_LOW   = '0;
        centroide   = '0;
        regra_ativa = {N{1'b1}};
    endtask

    task automatic set_rule(input int i, input logic [7:0] up, input logic [7:0] low, input logic [7:0] c);
        regra_UP[i*W +: W]  = up;
        regra_LOW[i*W +: W] = low;
        centroide[i*W +: W] = c;
    endtask

    // Runs one computation. start is held until an enabled edge takes it,
    // optionally re-pulsed at enabled cycle pulse_at. Stimulus is scrambled
    // right after capture to show the captured copy is what gets used.
    task automatic run(input logic toggle, input int pulse_at,
                       output int ec, output int cc, output logic sd);
        ec = 0;
        cc = 0;
        sd = 1'b0;
        start   = 1'b1;
        EN_SCLK = toggle ? 1'b0 : 1'b1;
        while (!sd && cc < 200) begin
            @(posedge clk);
            #1;
            cc++;
            if (EN_SCLK) begin
                ec++;
                if (ec == 1) begin
                    regra_UP  = {N{8'hA5}};
                    regra_LOW = {N{8'h3C}};
                    centroide = {N{8'h77}};
                end
            end
            start = (ec == 0) || (ec == pulse_at);
            if (done) sd = 1'b1;
            if (toggle) EN_SCLK = ~EN_SCLK;
        end
        start = 1'b0;
        if (!sd) begin
            errors++;
            $error("FAIL timeout waiting for done");
        end
    endtask

    task automatic settle();
        EN_SCLK = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        EN_SCLK = 1'b1;
        start = 1'b0;
        clear_rules();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 16'(busy), 16'd0);
        chk("reset_done", 16'(done), 16'd0);
        chk("reset_saida", 16'(saida_crisp), 16'd0);
        RESET = 1'b1;
        @(posedge clk);
        #1;

        // Case 1: single rule, weight 510, centroid 40
        clear_rules();
        set_rule(0, 8'd255, 8'd255, 8'd40);
        run(1'b0, 0, en_cyc, clk_cyc, saw_done);
        chk("c1_latency", 16'(en_cyc), 16'd19);
        chk("c1_saida", 16'(saida_crisp), 16'd40);
        chk("c1_busy_with_done", 16'(busy), 16'd1);
        @(posedge clk);
        #1;
        chk("c1_busy_after", 16'(busy), 16'd0);
        chk("c1_done_after", 16'(done), 16'd0);
        settle();

        // Case 3: all firings zero
        clear_rules();
        run(1'b0, 0, en_cyc, clk_cyc, saw_done);
        chk("c3_latency", 16'(en_cyc), 16'd19);
`ifdef DEFUZ_ZERO_FLAG_EN
        chk("c3_erro", 16'(erro_zero), 16'd1);
        chk("c3_saida_hold", 16'(saida_crisp), 16'd40);
`else
        chk("c3_saida_mid", 16'(saida_crisp), 16'd128);
`endif
        settle();

        // Case 2: 127.5 rounds up to 128
        clear_rules();
        set_rule(0, 8'd200, 8'd100, 8'd0);
        set_rule(1, 8'd200, 8'd100, 8'd255);
        run(1'b0, 0, en_cyc, clk_cyc, saw_done);
        chk("c2_saida", 16'(saida_crisp), 16'd128);
`ifdef DEFUZ_ZERO_FLAG_EN
        chk("c2_erro_clear", 16'(erro_zero), 16'd0);
`endif
        settle();

        // Case 4: EN_SCLK toggling every clock, case 1 stimulus
        clear_rules();
        set_rule(0, 8'd255, 8'd255, 8'd40);
        run(1'b1, 0, en_cyc, clk_cyc, saw_done);
        chk("c4_en_cycles", 16'(en_cyc), 16'd19);
        chk("c4_clk_edges", 16'(clk_cyc), 16'd38);
        chk("c4_saida", 16'(saida_crisp), 16'd40);
        settle();

        // Case 5: reset during ACUM aborts without done
        clear_rules();
        set_rule(0, 8'd200, 8'd100, 8'd0);
        set_rule(1, 8'd200, 8'd100, 8'd255);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("c5_busy_in_acum", 16'(busy), 16'd1);
        RESET = 1'b0;
        @(posedge clk);
        #1;
        RESET = 1'b1;
        chk("c5_busy", 16'(busy), 16'd0);
        chk("c5_saida", 16'(saida_crisp), 16'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("c5_no_done", 16'(saw_done), 16'd0);
        clear_rules();
        set_rule(0, 8'd200, 8'd100, 8'd0);
        set_rule(1, 8'd200, 8'd100, 8'd255);
        run(1'b0, 0, en_cyc, clk_cyc, saw_done);
        chk("c5_after_saida", 16'(saida_crisp), 16'd128);
        settle();

        // Case 6: extra start while busy, rule 1 masked
        clear_rules();
        set_rule(0, 8'd200, 8'd100, 8'd0);
        set_rule(1, 8'd200, 8'd100, 8'd255);
        regra_ativa[1] = 1'b0;
        run(1'b0, 5, en_cyc, clk_cyc, saw_done);
        chk("c6_latency", 16'(en_cyc), 16'd19);
        chk("c6_saida", 16'(saida_crisp), 16'd0);
        settle();
        chk("c6_idle_busy", 16'(busy), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
